pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 16-bit pipelined MIPS core.
- Drives the enable, flush and bubble controls of the PC, IF_ID, ID_EX and EX_MEM pipeline registers.
- Resolves load-use stalls, taken-branch flushes, data-memory wait freezes and a software halt/drain sequence.
- Sits beside the pipeline registers, fed from the ID stage fields and the ID_EX/EX_MEM outputs.

Parameters:
- DRAIN_CYCLES, 3: NOP-insertion cycles in HALT_DRAIN before HALTED.
- MEM_TIMEOUT, 15: consecutive mem_busy cycles before sticky mem_timeout is raised.
- REG_W, 3: register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_rs  in  REG_W  source register of the instruction in ID.
- id_rt  in  REG_W  second source register of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt.
- ex_memRead  in  1  memRead_out_pipe_2 (load in EX).
- ex_rt  in  REG_W  rt_out_pipe_2 (load destination).
- mem_branch_taken  in  1  branch resolved taken in MEM stage.
- mem_busy  in  1  data memory not ready this cycle.
- halt_req  in  1  halt request pulse.
- resume  in  1  leave HALTED.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF_ID register enable.
- if_id_flush  out  1  load NOP into IF_ID.
- id_ex_en  out  1  ID_EX register enable (drives its en).
- id_ex_bubble  out  1  zero all ID_EX control bits (regWrite, memRead, memWrite, branch).
- ex_mem_en  out  1  EX_MEM register enable.
- ex_mem_flush  out  1  zero EX_MEM control bits.
- halted  out  1  core halted.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- State register only; outputs are a combinational (Mealy) function of state and current inputs.
- States: RUN, HALT_DRAIN, HALTED (encoding from package).
- Reset (async, while rst=1):
  - State=RUN; halt_pend=0; drain counter=0; busy counter=0; mem_timeout=0.
  - Outputs forced: all *_en=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, halted=0.
- Load-use hazard LU = ex_memRead & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))). Register 0 never hazards.
- Priority in RUN, highest first:
  1. mem_busy: all *_en=0, no flush/bubble; whole pipe frozen. Busy counter increments, saturating at MEM_TIMEOUT. On reaching MEM_TIMEOUT, mem_timeout=1 until rst. Counter clears on first cycle with mem_busy=0.
  2. mem_branch_taken: all enables=1; if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. Three wrong-path instructions are squashed; LU is ignored that cycle.
  3. LU: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1. Exactly one stall cycle, because the bubble clears ex_memRead.
  4. Otherwise: all enables=1, no flush/bubble.
- Halt handling:
  - halt_req arriving in any cycle sets halt_pend.
  - In RUN with halt_pend=1 and no event 1–3: enter HALT_DRAIN, clear halt_pend.
- HALT_DRAIN:
  - pc_en=0, if_id_en=1, if_id_flush=1; other stages enabled so in-flight instructions retire.
  - Drain counter counts DRAIN_CYCLES cycles, then HALTED.
  - mem_busy freezes everything and pauses the counter.
  - mem_branch_taken during drain applies its flushes; PC is still held.
- HALTED:
  - halted=1; all *_en=0.
  - resume=1 → RUN next cycle (halted=0 in RUN).
  - halt_req in HALTED is ignored.
- Reset mid-drain or in HALTED: immediate return to RUN reset values.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[15:0] and flush_events[15:0], both saturating at 16'hFFFF and cleared by rst.
  - stall_cycles increments on every LU or mem_busy cycle.
  - flush_events increments on every cycle in which mem_branch_taken is acted on.
- Undefined: the ports still exist, tied to 16'h0000; no counter logic is built.

Decomposition:
- Package pipe_ctrl_pkg holds: state enum (RUN=2'd0, HALT_DRAIN=2'd1, HALTED=2'd2), REG_ZERO=3'd0, and the stats counter width constant STAT_W=16.
- Sub-module sat_counter (width parameter; inc, clr, value) is used for the busy counter, drain counter and both stats counters.

Test Plan:
- Load-use: ex_memRead=1, ex_rt=3, id_rs=3 → one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1. Repeat with ex_rt=0 → no stall.
- Branch plus LU in the same cycle → if_id_flush=id_ex_bubble=ex_mem_flush=1 and pc_en=1; no stall issued.
- mem_busy held 20 cycles → all *_en=0 for 20 cycles, mem_timeout=1 from cycle 15 onward; stays 1 after mem_busy drops, until rst.
- halt_req pulse during an LU stall → stall completes first, then 3 cycles of HALT_DRAIN (pc_en=0, if_id_flush=1), then halted=1. resume → RUN next cycle.
- rst asserted asynchronously mid-HALT_DRAIN (between edges) → outputs take reset values immediately; after release, state is RUN and halted=0.
- HAZARD_STATS_EN defined: 2 LU stalls + 4 busy cycles + 1 flush → stall_cycles=6, flush_events=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } ctrlState_t;

  localparam logic [2:0] REG_ZERO = 3'd0;
  localparam int unsigned STAT_W  = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX.
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != MAX)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 16-bit MIPS pipeline: load-use stalls, branch
// flushes, data-memory freezes and halt/drain. Outputs are a Mealy function
// of state and inputs. Optional macro HAZARD_STATS_EN builds the stall/flush
// statistics counters; otherwise those ports are tied to zero.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned REG_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memRead,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              mem_branch_taken,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_bubble,
  output logic              ex_mem_en,
  output logic              ex_mem_flush,
  output logic              halted,
  output logic              mem_timeout,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  localparam int unsigned BUSY_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  ctrlState_t         state;
  logic               haltPend;
  logic               timeoutFlag;
  logic [BUSY_W-1:0]  busyCnt;
  logic [DRAIN_W-1:0] drainCnt;
  logic               luHazard;
  logic               runIdle;
  logic               inDrain;
  logic               drainDone;

  // Load in EX whose destination feeds the ID instruction; r0 never hazards.
  assign luHazard = ex_memRead && (ex_rt != REG_W'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign runIdle   = (state == RUN) && !mem_busy && !mem_branch_taken && !luHazard;
  assign inDrain   = (state == HALT_DRAIN);
  assign drainDone = inDrain && !mem_busy && (drainCnt == DRAIN_W'(DRAIN_CYCLES - 1));

  // Consecutive busy cycles; clears on the first ready cycle.
  sat_counter #(.WIDTH(BUSY_W), .MAX(BUSY_W'(MEM_TIMEOUT))) u_busyCnt (
    .clk(clk), .rst(rst), .inc(mem_busy), .clr(!mem_busy), .value(busyCnt)
  );

  // Drain progress; paused by mem_busy, cleared outside drain and on exit.
  sat_counter #(.WIDTH(DRAIN_W), .MAX(DRAIN_W'(DRAIN_CYCLES))) u_drainCnt (
    .clk(clk), .rst(rst), .inc(inDrain && !mem_busy), .clr(!inDrain || drainDone),
    .value(drainCnt)
  );

  // State, pending-halt and sticky timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      haltPend    <= 1'b0;
      timeoutFlag <= 1'b0;
    end else begin
      case (state)
        RUN:        if (runIdle && haltPend) state <= HALT_DRAIN;
        HALT_DRAIN: if (drainDone) state <= HALTED;
        HALTED:     if (resume) state <= RUN;
        default:    state <= RUN;
      endcase
      if (runIdle && haltPend) begin
        haltPend <= 1'b0;
      end else if (halt_req && (state != HALTED)) begin
        haltPend <= 1'b1;
      end
      if (mem_busy && (busyCnt == BUSY_W'(MEM_TIMEOUT - 1))) begin
        timeoutFlag <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeoutFlag;

  // Pipeline register controls from state and current hazards.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            pc_en = 1'b0;
          end else if (mem_branch_taken) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (luHazard) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b1;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
          end
        end
        HALT_DRAIN: begin
          if (!mem_busy) begin
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            id_ex_bubble = mem_branch_taken;
            ex_mem_flush = mem_branch_taken;
          end
        end
        HALTED: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic stallInc;
  logic flushInc;

  assign stallInc = mem_busy || ((state == RUN) && !mem_branch_taken && luHazard);
  assign flushInc = !mem_busy && mem_branch_taken && ((state == RUN) || inDrain);

  // Stall cycles (load-use or memory wait), saturating.
  sat_counter #(.WIDTH(STAT_W)) u_stallCnt (
    .clk(clk), .rst(rst), .inc(stallInc), .clr(1'b0), .value(stall_cycles)
  );

  // Branch flushes acted on, saturating.
  sat_counter #(.WIDTH(STAT_W)) u_flushCnt (
    .clk(clk), .rst(rst), .inc(flushInc), .clr(1'b0), .value(flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
